iterative_shift_unit: RTL and testbench

//   Multi-cycle, parametrised shifter/rotator for the ALU shift path.

---
 rtl/iterative_shift_unit.sv | 149 ++++++++++++++
 tb/tb_iterative_shift_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter, STEP bit positions per clock.
// Optional CARRY/ZERO flags when SHIFT_UNIT_FLAGS_EN is defined.
module iterative_shift_unit #(
    parameter int DATA_W = 8,
    parameter int STEP   = 1,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [1:0]         MODE,
    input  logic [DATA_W-1:0]  DATA_IN,
    input  logic [SHAMT_W-1:0] SHAMT,
    output logic               BUSY,
    output logic               DONE,
    output logic [DATA_W-1:0]  RESULT
`ifdef SHIFT_UNIT_FLAGS_EN
    ,
    output logic               CARRY,
    output logic               ZERO
`endif
);

    localparam logic [SHAMT_W-1:0] STEP_V  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   WIDTH_V = (SHAMT_W + 1)'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0]  work;
    logic [DATA_W-1:0]  work_nxt;
    logic [DATA_W-1:0]  lsl_v;
    logic [DATA_W-1:0]  lsr_v;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] step_amt;
    logic [1:0]         mode_q;
    logic               accept;

`ifdef SHIFT_UNIT_FLAGS_EN
    logic lsl_c;
    logic lsr_c;
    logic carry_work;
    logic carry_nxt;
`endif

    assign accept   = START && (state == S_IDLE || state == S_DONE);
    assign step_amt = (rem > STEP_V) ? STEP_V : rem;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (START) state_nxt = S_SHIFT;
            S_SHIFT: if (rem == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = START ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        BUSY = (state == S_SHIFT);
        DONE = (state == S_DONE);
    end

    // One partial shift of the working register; the spill bit is the carry
    always_comb begin
`ifdef SHIFT_UNIT_FLAGS_EN
        {lsl_c, lsl_v} = {1'b0, work} << step_amt;
        {lsr_v, lsr_c} = {work, 1'b0} >> step_amt;
`else
        lsl_v = work << step_amt;
        lsr_v = work >> step_amt;
`endif
        work_nxt = work;
        case (mode_q)
            2'b00:   work_nxt = lsl_v;
            2'b01:   work_nxt = lsr_v;
            2'b10:   work_nxt = $signed(work) >>> step_amt;
            default: work_nxt = lsr_v
                              | (work << (WIDTH_V - {1'b0, step_amt}));
        endcase
    end

`ifdef SHIFT_UNIT_FLAGS_EN
    // ROR carry tracks the MSB so it equals RESULT MSB (0 if no step taken)
    always_comb begin
        carry_nxt = carry_work;
        case (mode_q)
            2'b00:   carry_nxt = lsl_c;
            2'b01:   carry_nxt = lsr_c;
            2'b10:   carry_nxt = lsr_c;
            default: carry_nxt = work_nxt[DATA_W-1];
        endcase
    end
`endif

    // Operand latch, iterative shift and result/flag capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            work   <= '0;
            rem    <= '0;
            mode_q <= 2'b00;
            RESULT <= '0;
`ifdef SHIFT_UNIT_FLAGS_EN
            carry_work <= 1'b0;
            CARRY      <= 1'b0;
            ZERO       <= 1'b1;
`endif
        end else if (accept) begin
            work   <= DATA_IN;
            rem    <= SHAMT;
            mode_q <= MODE;
`ifdef SHIFT_UNIT_FLAGS_EN
            carry_work <= 1'b0;
`endif
        end else if (state == S_SHIFT) begin
            if (rem != '0) begin
                work <= work_nxt;
                rem  <= rem - step_amt;
`ifdef SHIFT_UNIT_FLAGS_EN
                carry_work <= carry_nxt;
`endif
            end else begin
                RESULT <= work;
`ifdef SHIFT_UNIT_FLAGS_EN
                CARRY <= carry_work;
                ZERO  <= (work == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit (8-bit/STEP 1 and 16-bit/STEP 4).
// Flag checks are compiled in when SHIFT_UNIT_FLAGS_EN is defined.
module tb_iterative_shift_unit;

    localparam int STEP_N = 1;
    localparam int STEP_W = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [1:0]  MODE;
    logic [7:0]  DATA_IN;
    logic [2:0]  SHAMT;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  RESULT;

    logic        W_START;
    logic [1:0]  W_MODE;
    logic [15:0] W_DATA;
    logic [3:0]  W_SHAMT;
    logic        W_BUSY;
    logic        W_DONE;
    logic [15:0] W_RESULT;

`ifdef SHIFT_UNIT_FLAGS_EN
    logic CARRY, ZERO, W_CARRY, W_ZERO;
`endif

    int n_cmp = 0;
    int n_err = 0;

    iterative_shift_unit #(.DATA_W(8), .STEP(STEP_N)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
        .DATA_IN(DATA_IN), .SHAMT(SHAMT), .BUSY(BUSY), .DONE(DONE),
        .RESULT(RESULT)
`ifdef SHIFT_UNIT_FLAGS_EN
        , .CARRY(CARRY), .ZERO(ZERO)
`endif
    );

    iterative_shift_unit #(.DATA_W(16), .STEP(STEP_W)) dut_w (
        .CLK(CLK), .RESET(RESET), .START(W_START), .MODE(W_MODE),
        .DATA_IN(W_DATA), .SHAMT(W_SHAMT), .BUSY(W_BUSY), .DONE(W_DONE),
        .RESULT(W_RESULT)
`ifdef SHIFT_UNIT_FLAGS_EN
        , .CARRY(W_CARRY), .ZERO(W_ZERO)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-operation reference: final value and last bit shifted out
    function automatic void model(input int w, input logic [1:0] m,
                                  input logic [31:0] v, input int n,
                                  output logic [31:0] r, output logic c);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        v = v & mask;
        c = 1'b0;
        case (m)
            2'b00: begin
                r = (v << n) & mask;
                if (n != 0) c = v[w-n];
            end
            2'b01: begin
                r = v >> n;
                if (n != 0) c = v[n-1];
            end
            2'b10: begin
                r = v >> n;
                if (v[w-1]) r = r | (mask & ~(mask >> n));
                if (n != 0) c = v[n-1];
            end
            default: begin
                r = ((v >> n) | (v << (w - n))) & mask;
                if (n != 0) c = r[w-1];
            end
        endcase
    endfunction

    task automatic start8(input logic [1:0] m, input logic [7:0] d,
                          input logic [2:0] n);
        MODE = m;
        DATA_IN = d;
        SHAMT = n;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        DATA_IN = 8'($urandom);
        MODE = 2'($urandom);
        SHAMT = 3'($urandom);
    endtask

    task automatic wait8(output int cnt);
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 64) begin
            cnt++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_out8(input string tag, input logic [1:0] m,
                              input logic [7:0] d, input int n);
        logic [31:0] r;
        logic c;
        model(8, m, {24'h0, d}, n, r, c);
        check({tag, "_done"}, {31'h0, DONE}, 32'h1);
        check({tag, "_res"}, {24'h0, RESULT}, r);
`ifdef SHIFT_UNIT_FLAGS_EN
        check({tag, "_carry"}, {31'h0, CARRY}, {31'h0, c});
        check({tag, "_zero"}, {31'h0, ZERO}, {31'h0, r == 0});
`else
        c = c;
`endif
    endtask

    task automatic run8(input string tag, input logic [1:0] m,
                        input logic [7:0] d, input logic [2:0] n);
        int cnt;
        logic [7:0] hold;
        start8(m, d, n);
        wait8(cnt);
        check({tag, "_busy"}, cnt, (int'(n) + STEP_N - 1) / STEP_N + 1);
        check_out8(tag, m, d, int'(n));
        hold = RESULT;
        @(posedge CLK);
        #1;
        check({tag, "_pulse"}, {30'h0, DONE, BUSY}, 32'h0);
        check({tag, "_hold"}, {24'h0, RESULT}, {24'h0, hold});
    endtask

    task automatic runw(input string tag, input logic [1:0] m,
                        input logic [15:0] d, input logic [3:0] n);
        int cnt;
        logic [31:0] r;
        logic c;
        model(16, m, {16'h0, d}, int'(n), r, c);
        W_MODE = m;
        W_DATA = d;
        W_SHAMT = n;
        W_START = 1'b1;
        @(posedge CLK);
        #1;
        W_START = 1'b0;
        W_DATA = 16'($urandom);
        cnt = 0;
        while (W_BUSY === 1'b1 && cnt < 64) begin
            cnt++;
            @(posedge CLK);
            #1;
        end
        check({tag, "_busy"}, cnt, (int'(n) + STEP_W - 1) / STEP_W + 1);
        check({tag, "_done"}, {31'h0, W_DONE}, 32'h1);
        check({tag, "_res"}, {16'h0, W_RESULT}, r);
`ifdef SHIFT_UNIT_FLAGS_EN
        check({tag, "_carry"}, {31'h0, W_CARRY}, {31'h0, c});
        check({tag, "_zero"}, {31'h0, W_ZERO}, {31'h0, r == 0});
`endif
        @(posedge CLK);
        #1;
        check({tag, "_pulse"}, {31'h0, W_DONE}, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic seen;
        RESET = 1'b1;
        START = 1'b0;
        MODE = 2'b00;
        DATA_IN = 8'h00;
        SHAMT = 3'h0;
        W_START = 1'b0;
        W_MODE = 2'b00;
        W_DATA = 16'h0;
        W_SHAMT = 4'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_done", {31'h0, DONE}, 32'h0);
        check("rst_res", {24'h0, RESULT}, 32'h0);
`ifdef SHIFT_UNIT_FLAGS_EN
        check("rst_carry", {31'h0, CARRY}, 32'h0);
        check("rst_zero", {31'h0, ZERO}, 32'h1);
`endif
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        run8("asr90", 2'b10, 8'h90, 3'd3);
        check("asr90_const", {24'h0, RESULT}, 32'hF2);
        run8("lsl81", 2'b00, 8'h81, 3'd1);
        run8("lsr80", 2'b01, 8'h80, 3'd7);
        check("lsr80_const", {24'h0, RESULT}, 32'h01);
        run8("lsr01", 2'b01, 8'h01, 3'd1);
        run8("rorb4", 2'b11, 8'hB4, 3'd4);
        check("rorb4_const", {24'h0, RESULT}, 32'h4B);
        run8("zero5a", 2'b00, 8'h5A, 3'd0);
        run8("rorz", 2'b11, 8'hA5, 3'd0);
        run8("asr7", 2'b10, 8'h80, 3'd7);

        // START pulse mid-shift must be ignored
        start8(2'b00, 8'h0F, 3'd2);
        DATA_IN = 8'hFF;
        MODE = 2'b11;
        SHAMT = 3'd7;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait8(cnt);
        check("mid_busy", cnt + 1, 3);
        check_out8("mid", 2'b00, 8'h0F, 2);
        check("mid_const", {24'h0, RESULT}, 32'h3C);

        // Back-to-back issue during the DONE cycle
        start8(2'b01, 8'hC3, 3'd2);
        check("b2b_noidle", {31'h0, BUSY}, 32'h1);
        wait8(cnt);
        check("b2b_busy", cnt, 3);
        check_out8("b2b", 2'b01, 8'hC3, 2);
        @(posedge CLK);
        #1;

        // Reset during the second SHIFT cycle aborts the operation
        start8(2'b01, 8'hF0, 3'd5);
        @(posedge CLK);
        #1;
        check("abort_shift2", {31'h0, BUSY}, 32'h1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("abort_busy", {31'h0, BUSY}, 32'h0);
        check("abort_done", {31'h0, DONE}, 32'h0);
        check("abort_res", {24'h0, RESULT}, 32'h0);
`ifdef SHIFT_UNIT_FLAGS_EN
        check("abort_zero", {31'h0, ZERO}, 32'h1);
        check("abort_carry", {31'h0, CARRY}, 32'h0);
`endif
        seen = 1'b0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (DONE !== 1'b0) seen = 1'b1;
        end
        check("abort_nodone", {31'h0, seen}, 32'h0);

        for (int i = 0; i < 40; i++) begin
            run8("rnd8", 2'($urandom), 8'($urandom), 3'($urandom));
        end

        runw("w_ror", 2'b11, 16'h1234, 4'd5);
        check("w_ror_const", {16'h0, W_RESULT}, 32'hA091);
        runw("w_asr", 2'b10, 16'h8001, 4'd15);
        runw("w_zero", 2'b01, 16'hBEEF, 4'd0);
        for (int i = 0; i < 20; i++) begin
            runw("rndw", 2'($urandom), 16'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
